// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : shared prefetch types (state encoding, buffer entry, counter width)
// Rev 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    PF_IDLE  = 2'd0,
    PF_FETCH = 2'd1,
    PF_ABORT = 2'd2,
    PF_HALT  = 2'd3
  } pf_state_t;

  localparam int c_pf_addr_width = 32;
  localparam int c_pf_data_width = 32;
  localparam int c_pf_depth      = 4;
  localparam int c_pf_cnt_width  = $clog2(c_pf_depth) + 1;

  typedef struct packed {
    logic                       error;
    logic [c_pf_addr_width-1:0] pc;
    logic [c_pf_data_width-1:0] data;
  } pf_entry_t;

  // Holds 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prefetch_fifo : synchronous FIFO with flush; flush beats push and pop
// Rev 1.0
// ----------------------------------------------------------------------------
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 65,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     head,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_WIDTH-1:0] r_wr_ptr;
  logic [PTR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & (r_count != CNT_WIDTH'(DEPTH));
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      r_count <= r_count + CNT_WIDTH'(w_do_push) - CNT_WIDTH'(w_do_pop);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/wb_prefetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_prefetch : pipelined Wishbone B4 instruction prefetcher with flush/error
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_prefetch
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int INSN_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_restart,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_error,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_err
);

  localparam int CNT_WIDTH   = cnt_width(DEPTH);
  localparam int SUM_WIDTH   = CNT_WIDTH + 1;
  localparam int ENTRY_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;

  pf_state_t               r_state;
  pf_state_t               w_state_next;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic [ADDR_WIDTH-1:0]   r_resp_addr;
  logic [CNT_WIDTH-1:0]    r_outstanding;
  logic [CNT_WIDTH-1:0]    w_count;
  logic                    w_empty;
  logic                    w_credit;
  logic                    w_accept;
  logic                    w_ack_take;
  logic                    w_err_take;
  logic                    w_push;
  logic                    w_pop;
  logic [ENTRY_WIDTH-1:0]  w_push_entry;
  logic [ENTRY_WIDTH-1:0]  w_head;

  assign o_wb_cyc  = (r_state == PF_FETCH);
  assign o_wb_we   = 1'b0;
  assign o_wb_addr = r_req_addr;

  // Credit uses the registered count, so a pop only frees a slot next cycle.
  assign w_credit = (SUM_WIDTH'(w_count) + SUM_WIDTH'(r_outstanding)) < SUM_WIDTH'(DEPTH);
  // Gating with restart keeps a request from being issued on the flush edge.
  assign o_wb_stb = o_wb_cyc & ~i_restart & w_credit;
  assign w_accept = o_wb_stb & ~i_wb_stall;

  assign w_err_take = o_wb_cyc & ~i_restart & i_wb_err;
  assign w_ack_take = o_wb_cyc & ~i_restart & i_wb_ack & ~i_wb_err & (r_outstanding != '0);
  assign w_push     = w_ack_take | w_err_take;
  assign w_push_entry = w_err_take ? {1'b1, r_resp_addr, {DATA_WIDTH{1'b0}}}
                                   : {1'b0, r_resp_addr, i_wb_data};

  assign o_valid = ~w_empty;
  assign w_pop   = o_valid & i_ready;
  assign {o_error, o_pc, o_instruction} = o_valid ? w_head : '0;

  prefetch_fifo #(
    .WIDTH     (ENTRY_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (i_restart),
    .din   (w_push_entry),
    .head  (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PF_IDLE, PF_HALT: if (i_restart) w_state_next = PF_FETCH;
      PF_FETCH: begin
        if (i_restart)       w_state_next = (r_outstanding != '0) ? PF_ABORT : PF_FETCH;
        else if (w_err_take) w_state_next = PF_HALT;
      end
      PF_ABORT: w_state_next = PF_FETCH;
      default:  w_state_next = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= PF_IDLE;
      r_req_addr    <= '0;
      r_resp_addr   <= '0;
      r_outstanding <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_restart) begin
        r_req_addr    <= i_pc;
        r_resp_addr   <= i_pc;
        r_outstanding <= '0;
      end else begin
        if (w_accept) r_req_addr  <= r_req_addr + ADDR_WIDTH'(INSN_BYTES);
        if (w_push)   r_resp_addr <= r_resp_addr + ADDR_WIDTH'(INSN_BYTES);
        // An error abandons whatever responses are still in flight.
        if (w_err_take) r_outstanding <= '0;
        else            r_outstanding <= r_outstanding + CNT_WIDTH'(w_accept) - CNT_WIDTH'(w_ack_take);
      end
    end
  end

endmodule
`default_nettype wire
